// File: rtl/rfphoenix_hptw_if.sv
// Miss-request, memory-bus and refill-result signals of the rfPhoenix hashed page-table walker.
// The walker takes the slave view; the TLB refill logic and the memory bus together take the master view.
interface rfphoenix_hptw_if;
  logic [31:0]  ptbr_i;
  logic         miss_v_i;
  logic         miss_rdy_o;
  logic [31:0]  miss_adr_i;
  logic [9:0]   miss_asid_i;
  logic         cyc_o;
  logic         stb_o;
  logic [31:0]  adr_o;
  logic         ack_i;
  logic         err_i;
  logic [127:0] dat_i;
  logic         tlbe_v_o;
  logic [127:0] tlbe_o;
  logic         fault_o;
  logic         berr_o;

  modport slave (
    input  ptbr_i, miss_v_i, miss_adr_i, miss_asid_i, ack_i, err_i, dat_i,
    output miss_rdy_o, cyc_o, stb_o, adr_o, tlbe_v_o, tlbe_o, fault_o, berr_o
  );

  modport master (
    output ptbr_i, miss_v_i, miss_adr_i, miss_asid_i, ack_i, err_i, dat_i,
    input  miss_rdy_o, cyc_o, stb_o, adr_o, tlbe_v_o, tlbe_o, fault_o, berr_o
  );
endinterface

// File: rtl/rfphoenix_hptw.sv
// Hashed page-table walker: reads the eight HPTEs of a hashed group and returns a TLBE or a fault.
// Optional secondary-group probe is enabled by defining RFPHOENIX_HPTW_SECOND_PROBE_EN.
module rfphoenix_hptw #(
  parameter int HASH_BITS = 10
) (
  input logic             clk_i,
  input logic             rst_i,
  rfphoenix_hptw_if.slave hif
);

  // HPTE layout, MSB first; v is bit 0.
  typedef struct packed {
    logic [31:0] ppnhi;
    logic [15:0] ppn;
    logic [15:0] vpnhi;
    logic [15:0] vpn;
    logic [9:0]  asid;
    logic [24:0] rsvd;
    logic [2:0]  c;
    logic        a;
    logic [2:0]  rwx;
    logic        m;
    logic [2:0]  lvl;
    logic        g;
    logic        v;
  } hpte_t;

  // TLBE layout, MSB first; v is bit 0.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] vpn;
    logic [39:0] ppn;
    logic [9:0]  asid;
    logic        pad1;
    logic [2:0]  c;
    logic        a;
    logic [2:0]  rwx;
    logic        m;
    logic        g;
    logic [2:0]  lvl;
    logic        v;
  } tlbe_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] CHK  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic [2:0]  beat;
  logic [31:0] grp_base;
  logic [17:0] vpn_q;
  logic [9:0]  asid_q;
  logic [31:0] adr_q;
  hpte_t       hpte;
  tlbe_t       tlbe;
  tlbe_t       tlbe_nxt;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        tlbe_v;
  logic        fault;
  logic        berr;
  logic        hit;

  logic [17:0]          vpn_in;
  logic [HASH_BITS-1:0] hash;
  logic [31:0]          base_in;
  logic [2:0]           beat_nxt;

  assign vpn_in   = hif.miss_adr_i[31:14];
  assign hash     = HASH_BITS'(vpn_in) ^ HASH_BITS'(hif.miss_asid_i);
  assign base_in  = hif.ptbr_i + 32'({hash, 7'b0});
  assign beat_nxt = beat + 3'd1;

`ifdef RFPHOENIX_HPTW_SECOND_PROBE_EN
  logic        probe;
  logic [31:0] alt_base;
  logic [31:0] alt_base_in;

  assign alt_base_in = hif.ptbr_i + 32'({~hash, 7'b0});
`endif

  assign hit = hpte.v
            && (hpte.vpn == vpn_q[15:0])
            && (hpte.vpnhi == {14'b0, vpn_q[17:16]})
            && (hpte.g || (hpte.asid == asid_q));

  // NOTE: every field gets a default first so no path through this block can infer a latch.
  always_comb begin
    tlbe_nxt      = '0;
    tlbe_nxt.adr  = adr_q;
    tlbe_nxt.vpn  = {14'b0, vpn_q};
    tlbe_nxt.ppn  = {hpte.ppnhi[23:0], hpte.ppn};
    tlbe_nxt.asid = hpte.asid;
    tlbe_nxt.c    = hpte.c;
    tlbe_nxt.a    = hpte.a;
    tlbe_nxt.rwx  = hpte.rwx;
    tlbe_nxt.m    = hpte.m;
    tlbe_nxt.g    = hpte.g;
    tlbe_nxt.lvl  = hpte.lvl;
    tlbe_nxt.v    = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      beat     <= '0;
      grp_base <= '0;
      vpn_q    <= '0;
      asid_q   <= '0;
      adr_q    <= '0;
      hpte     <= '0;
      tlbe     <= '0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      adr      <= '0;
      tlbe_v   <= 1'b0;
      fault    <= 1'b0;
      berr     <= 1'b0;
`ifdef RFPHOENIX_HPTW_SECOND_PROBE_EN
      probe    <= 1'b0;
      alt_base <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (hif.miss_v_i) begin
            vpn_q    <= vpn_in;
            asid_q   <= hif.miss_asid_i;
            adr_q    <= hif.miss_adr_i;
            grp_base <= base_in;
            beat     <= '0;
            adr      <= base_in;
            cyc      <= 1'b1;
            stb      <= 1'b1;
            state    <= REQ;
`ifdef RFPHOENIX_HPTW_SECOND_PROBE_EN
            probe    <= 1'b0;
            alt_base <= alt_base_in;
`endif
          end
        end
        REQ: begin
          // A bus error takes priority over a simultaneous ack.
          if (hif.err_i) begin
            cyc   <= 1'b0;
            stb   <= 1'b0;
            fault <= 1'b1;
            berr  <= 1'b1;
            state <= RESP;
          end else if (hif.ack_i) begin
            hpte  <= hif.dat_i;
            cyc   <= 1'b0;
            stb   <= 1'b0;
            state <= CHK;
          end
        end
        CHK: begin
          if (hit) begin
            tlbe   <= tlbe_nxt;
            tlbe_v <= 1'b1;
            state  <= RESP;
          end else if (beat != 3'd7) begin
            beat  <= beat_nxt;
            adr   <= grp_base + 32'({beat_nxt, 4'b0});
            cyc   <= 1'b1;
            stb   <= 1'b1;
            state <= REQ;
`ifdef RFPHOENIX_HPTW_SECOND_PROBE_EN
          end else if (!probe) begin
            probe    <= 1'b1;
            beat     <= '0;
            grp_base <= alt_base;
            adr      <= alt_base;
            cyc      <= 1'b1;
            stb      <= 1'b1;
            state    <= REQ;
`endif
          end else begin
            fault <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          tlbe_v <= 1'b0;
          fault  <= 1'b0;
          berr   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reserved HPTE bits and the top of ppnhi carry nothing the TLBE needs.
  logic unused_hpte_bits;
  assign unused_hpte_bits = ^{hpte.rsvd, hpte.ppnhi[31:24]};

  assign hif.miss_rdy_o = (state == IDLE);
  assign hif.cyc_o      = cyc;
  assign hif.stb_o      = stb;
  assign hif.adr_o      = adr;
  assign hif.tlbe_v_o   = tlbe_v;
  assign hif.tlbe_o     = tlbe;
  assign hif.fault_o    = fault;
  assign hif.berr_o     = berr;

endmodule

// File: tb/tb_rfphoenix_hptw.sv
// Scoreboard bench for rfphoenix_hptw: a memory model answers bus beats, expected results are queued per request.
// Build with RFPHOENIX_HPTW_SECOND_PROBE_EN defined to exercise the secondary-group probe.
module tb_rfphoenix_hptw;

  localparam logic [31:0] PTBR    = 32'h0010_0000;
  localparam logic [31:0] NO_ERR  = 32'hFFFF_FFFF;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  rfphoenix_hptw_if hif ();

  rfphoenix_hptw #(.HASH_BITS(10)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .hif   (hif)
  );

  typedef struct {
    bit           fault;
    bit           berr;
    logic [127:0] tlbe;
    int           lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [31:0]   exp_adr_q[$];
  logic [31:0]   rd_q[$];
  logic [127:0]  mem [logic [31:0]];
  logic [127:0]  last_tlbe = '0;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            wait_states = 0;
  logic [31:0]   err_adr = NO_ERR;
  bit            force_ack = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [127:0] mk_hpte(bit v, bit g, logic [9:0] asid, logic [17:0] vpn,
                                           logic [15:0] ppn, logic [31:0] ppnhi, logic [2:0] lvl,
                                           bit m, logic [2:0] rwx, bit a, logic [2:0] c);
    return {ppnhi, ppn, {14'b0, vpn[17:16]}, vpn[15:0], asid, 25'b0, c, a, rwx, m, lvl, g, v};
  endfunction

  function automatic logic [127:0] mk_tlbe(logic [31:0] adr, logic [127:0] h);
    return {adr, 14'b0, adr[31:14], h[119:96], h[95:80], h[47:38], 1'b0,
            h[12:10], h[9], h[8:6], h[5], h[1], h[4:2], 1'b1};
  endfunction

  function automatic logic [31:0] grp(logic [31:0] adr, logic [9:0] asid, bit second);
    logic [9:0] h;
    h = adr[23:14] ^ asid;
    if (second) h = ~h;
    return PTBR + {15'b0, h, 7'b0};
  endfunction

  function automatic int hit_lat(int k, int w);
    return 3 + k * (2 + w) + w;
  endfunction

  function automatic logic [127:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : 128'b0;
  endfunction

  task automatic push_exp(bit fault, bit berr, logic [127:0] tlbe, int lat);
    exp_t e;
    e.fault = fault;
    e.berr  = berr;
    e.tlbe  = tlbe;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  task automatic push_adrs(logic [31:0] base, int n);
    for (int k = 0; k < n; k++) exp_adr_q.push_back(base + 32'(16 * k));
  endtask

  // ---------------- memory bus responder ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    hif.ack_i = 1'b0;
    hif.err_i = 1'b0;
    hif.dat_i = '0;
    forever begin
      @(negedge clk_i);
      if (force_ack) begin
        hif.ack_i = 1'b1;
        hif.err_i = 1'b0;
        wcnt = 0;
      end else if (hif.cyc_o && hif.stb_o && !hif.ack_i && !hif.err_i) begin
        if (wcnt == wait_states) begin
          if (hif.adr_o == err_adr) hif.err_i = 1'b1;
          else begin
            hif.ack_i = 1'b1;
            hif.dat_i = mem_rd(hif.adr_o);
          end
          rd_q.push_back(hif.adr_o);
          wcnt = 0;
        end else wcnt++;
      end else begin
        hif.ack_i = 1'b0;
        hif.err_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- request driver + scoreboard compare ----------------
  task automatic run_miss(input logic [31:0] adr, input logic [9:0] asid);
    exp_t e;
    int   lat;
    bit   done;
    @(negedge clk_i);
    n_assert++;
    if (hif.miss_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_before_req: got %b want 1", hif.miss_rdy_o);
    end
    hif.miss_v_i    = 1'b1;
    hif.miss_adr_i  = adr;
    hif.miss_asid_i = asid;
    @(posedge clk_i);
    #1;
    hif.miss_v_i    = 1'b0;
    hif.miss_adr_i  = ~adr;
    hif.miss_asid_i = ~asid;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk_i);
      lat++;
      if (lat == 1 && exp_adr_q.size() > 0) begin
        n_assert++;
        if (hif.cyc_o !== 1'b1 || hif.stb_o !== 1'b1 || hif.adr_o !== exp_adr_q[0]) begin
          n_fail++;
          $display("FAIL first_beat: cyc=%b stb=%b adr=%h want 1 1 %h",
                   hif.cyc_o, hif.stb_o, hif.adr_o, exp_adr_q[0]);
        end
      end
      done = hif.tlbe_v_o || hif.fault_o;
    end
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got result with no expectation queued");
    end else if (!done) begin
      void'(exp_q.pop_front());
      n_fail++;
      $display("FAIL result_timeout: got no pulse in %0d cycles want one", lat);
    end else begin
      e = exp_q.pop_front();
      n_assert++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL result_latency: got T+%0d want T+%0d", lat, e.lat);
      end
      if (hif.fault_o !== e.fault || hif.tlbe_v_o !== !e.fault || hif.berr_o !== e.berr) begin
        n_fail++;
        $display("FAIL result_kind: got fault=%b tlbe_v=%b berr=%b want %b %b %b",
                 hif.fault_o, hif.tlbe_v_o, hif.berr_o, e.fault, !e.fault, e.berr);
      end
      n_assert++;
      if (hif.tlbe_o !== e.tlbe) begin
        n_fail++;
        $display("FAIL tlbe_value: got %h want %h", hif.tlbe_o, e.tlbe);
      end
      n_assert++;
      if (hif.cyc_o !== 1'b0 || hif.miss_rdy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL resp_bus_idle: got cyc=%b rdy=%b want 0 0", hif.cyc_o, hif.miss_rdy_o);
      end
      @(negedge clk_i);
      n_assert++;
      if (hif.tlbe_v_o !== 1'b0 || hif.fault_o !== 1'b0 || hif.berr_o !== 1'b0 || hif.miss_rdy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_width: got tlbe_v=%b fault=%b berr=%b rdy=%b want 0 0 0 1",
                 hif.tlbe_v_o, hif.fault_o, hif.berr_o, hif.miss_rdy_o);
      end
    end
    n_assert++;
    if (rd_q.size() != exp_adr_q.size()) begin
      n_fail++;
      $display("FAIL read_count: got %0d want %0d", rd_q.size(), exp_adr_q.size());
    end
    while (exp_adr_q.size() > 0 && rd_q.size() > 0) begin
      logic [31:0] ga, wa;
      ga = rd_q.pop_front();
      wa = exp_adr_q.pop_front();
      n_assert++;
      if (ga !== wa) begin
        n_fail++;
        $display("FAIL read_adr: got %h want %h", ga, wa);
      end
    end
    rd_q.delete();
    exp_adr_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    hif.ptbr_i      = PTBR;
    hif.miss_v_i    = 1'b0;
    hif.miss_adr_i  = '0;
    hif.miss_asid_i = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_assert++;
    if (hif.miss_rdy_o !== 1'b1 || hif.cyc_o !== 1'b0 || hif.stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b cyc=%b stb=%b want 1 0 0", hif.miss_rdy_o, hif.cyc_o, hif.stb_o);
    end
    n_assert++;
    if (hif.tlbe_v_o !== 1'b0 || hif.fault_o !== 1'b0 || hif.berr_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pulses: got tlbe_v=%b fault=%b berr=%b want 0 0 0", hif.tlbe_v_o, hif.fault_o, hif.berr_o);
    end
    n_assert++;
    if (hif.adr_o !== 32'h0 || hif.tlbe_o !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got adr=%h tlbe=%h want 0 0", hif.adr_o, hif.tlbe_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_hit_beat0();
    logic [31:0]  a;
    logic [9:0]   s;
    logic [127:0] h;
    a = 32'h0004_C000;
    s = 10'h005;
    mem.delete();
    h = mk_hpte(1, 0, s, a[31:14], 16'hBEEF, 32'hAB12_3456, 3'd1, 1, 3'b101, 1, 3'd2);
    mem[grp(a, s, 0)] = h;
    last_tlbe = mk_tlbe(a, h);
    push_exp(0, 0, last_tlbe, hit_lat(0, 0));
    push_adrs(grp(a, s, 0), 1);
    run_miss(a, s);
  endtask

  task automatic test_wait_states();
    logic [31:0]  a;
    logic [9:0]   s;
    logic [31:0]  b;
    logic [127:0] h;
    a = 32'h0004_C000;
    s = 10'h005;
    b = grp(a, s, 0);
    mem.delete();
    mem[b + 32'h00] = mk_hpte(0, 1, s, a[31:14], 16'h1111, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    mem[b + 32'h10] = mk_hpte(1, 1, s, a[31:14] ^ 18'h1, 16'h2222, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    mem[b + 32'h20] = mk_hpte(1, 1, s, a[31:14] ^ 18'h10000, 16'h3333, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    mem[b + 32'h30] = mk_hpte(1, 0, 10'h006, a[31:14], 16'h4444, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    h = mk_hpte(1, 0, s, a[31:14], 16'h5A5A, 32'hFF00_C0DE, 3'd2, 0, 3'b011, 1, 3'd5);
    mem[b + 32'h50] = h;
    wait_states = 2;
    last_tlbe = mk_tlbe(a, h);
    push_exp(0, 0, last_tlbe, hit_lat(5, 2));
    push_adrs(b, 6);
    run_miss(a, s);
    wait_states = 0;
  endtask

  task automatic test_global();
    logic [31:0]  a;
    logic [9:0]   s;
    logic [31:0]  b;
    logic [127:0] h;
    a = 32'h0004_C000;
    s = 10'h005;
    b = grp(a, s, 0);
    mem.delete();
    mem[b + 32'h10] = mk_hpte(1, 0, 10'h007, a[31:14], 16'h0BAD, 32'h0, 3'd0, 0, 3'b001, 0, 3'd0);
    h = mk_hpte(1, 1, 10'h007, a[31:14], 16'h600D, 32'h0012_3456, 3'd3, 1, 3'b110, 0, 3'd1);
    mem[b + 32'h20] = h;
    last_tlbe = mk_tlbe(a, h);
    push_exp(0, 0, last_tlbe, hit_lat(2, 0));
    push_adrs(b, 3);
    run_miss(a, s);
    n_assert++;
    if (hif.tlbe_o[4] !== 1'b1 || hif.tlbe_o[23:14] !== 10'h007) begin
      n_fail++;
      $display("FAIL global_fields: got g=%b asid=%h want 1 007", hif.tlbe_o[4], hif.tlbe_o[23:14]);
    end
  endtask

  task automatic test_no_match();
    logic [31:0] a;
    logic [9:0]  s;
    a = 32'h0004_C000;
    s = 10'h005;
    mem.delete();
    // A perfect match one group over must never be read.
    mem[grp(a, s, 0) + 32'h80] = mk_hpte(1, 1, s, a[31:14], 16'h7777, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    push_adrs(grp(a, s, 0), 8);
`ifdef RFPHOENIX_HPTW_SECOND_PROBE_EN
    push_adrs(grp(a, s, 1), 8);
    push_exp(1, 0, last_tlbe, 33);
`else
    push_exp(1, 0, last_tlbe, 17);
`endif
    run_miss(a, s);
  endtask

  task automatic test_bus_error();
    logic [31:0] a;
    logic [9:0]  s;
    logic [31:0] b;
    a = 32'h0004_C000;
    s = 10'h005;
    b = grp(a, s, 0);
    mem.delete();
    mem[b + 32'h50] = mk_hpte(1, 0, s, a[31:14], 16'h9999, 32'h0, 3'd0, 0, 3'b111, 0, 3'd0);
    err_adr = b + 32'h30;
    push_exp(1, 1, last_tlbe, 1 + 2 * 3 + 1);
    push_adrs(b, 4);
    run_miss(a, s);
    err_adr = NO_ERR;
  endtask

  task automatic test_back_to_back();
    logic [31:0]  a1, a2;
    logic [9:0]   s1, s2;
    logic [127:0] h1, h2;
    a1 = 32'hFFFF_C000;
    s1 = 10'h2A5;
    a2 = 32'h8000_4000;
    s2 = 10'h001;
    mem.delete();
    h1 = mk_hpte(1, 0, s1, a1[31:14], 16'hCAFE, 32'h00FE_DCBA, 3'd7, 1, 3'b100, 1, 3'd7);
    h2 = mk_hpte(1, 0, s2, a2[31:14], 16'h1234, 32'h0000_0042, 3'd4, 0, 3'b010, 1, 3'd3);
    mem[grp(a1, s1, 0) + 32'h70] = h1;
    mem[grp(a2, s2, 0) + 32'h30] = h2;
    last_tlbe = mk_tlbe(a1, h1);
    push_exp(0, 0, last_tlbe, hit_lat(7, 0));
    push_adrs(grp(a1, s1, 0), 8);
    run_miss(a1, s1);
    last_tlbe = mk_tlbe(a2, h2);
    push_exp(0, 0, last_tlbe, hit_lat(3, 0));
    push_adrs(grp(a2, s2, 0), 4);
    run_miss(a2, s2);
  endtask

  task automatic test_reset_mid_walk();
    logic [31:0]  a;
    logic [9:0]   s;
    logic [31:0]  b;
    logic [127:0] h;
    int           cnt;
    a = 32'h0004_C000;
    s = 10'h005;
    b = grp(a, s, 0);
    mem.delete();
    wait_states = 3;
    @(negedge clk_i);
    hif.miss_v_i    = 1'b1;
    hif.miss_adr_i  = a;
    hif.miss_asid_i = s;
    @(posedge clk_i);
    #1;
    hif.miss_v_i = 1'b0;
    cnt = 0;
    while (!(hif.cyc_o === 1'b1 && hif.adr_o === b + 32'h40) && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
    end
    n_assert++;
    if (cnt >= 200) begin
      n_fail++;
      $display("FAIL reach_beat4: got no beat-4 strobe in %0d cycles want one", cnt);
    end
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    n_assert++;
    if (hif.cyc_o !== 1'b0 || hif.stb_o !== 1'b0 || hif.miss_rdy_o !== 1'b1 || hif.adr_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got cyc=%b stb=%b rdy=%b adr=%h want 0 0 1 0",
               hif.cyc_o, hif.stb_o, hif.miss_rdy_o, hif.adr_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_states = 0;
    @(posedge clk_i);
    #1;
    force_ack = 1'b1;
    @(posedge clk_i);
    #1;
    force_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      n_assert++;
      if (hif.tlbe_v_o !== 1'b0 || hif.fault_o !== 1'b0 || hif.cyc_o !== 1'b0 || hif.miss_rdy_o !== 1'b1) begin
        n_fail++;
        $display("FAIL late_ack_ignored: got tlbe_v=%b fault=%b cyc=%b rdy=%b want 0 0 0 1",
                 hif.tlbe_v_o, hif.fault_o, hif.cyc_o, hif.miss_rdy_o);
      end
    end
    rd_q.delete();
    // Reset cleared tlbe_o; the next walk must complete normally.
    h = mk_hpte(1, 0, s, a[31:14], 16'hD00D, 32'h0000_00AA, 3'd1, 0, 3'b001, 0, 3'd0);
    mem[b + 32'h10] = h;
    last_tlbe = mk_tlbe(a, h);
    push_exp(0, 0, last_tlbe, hit_lat(1, 0));
    push_adrs(b, 2);
    run_miss(a, s);
  endtask

  initial begin
    test_reset();
    test_hit_beat0();
    test_wait_states();
    test_global();
    test_no_match();
    test_bus_error();
    test_back_to_back();
    test_reset_mid_walk();
    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
